// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, flag bit positions and FSM state encoding for alu_seq
// The 4-bit op encoding matches the execute-stage decoder and must not be renumbered.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_MUL  = 4'b0011,
    OP_DIV  = 4'b0100,
    OP_SHL  = 4'b0101,
    OP_SHR  = 4'b0110,
    OP_ADC  = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle between the execute stage and alu_seq
// master = issuing stage, slave = ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctrl;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             div_zero;

  modport master (
    output in_valid, a, b, alu_ctrl, carry_in, out_ready,
    input  in_ready, out_valid, result, flags, div_zero
  );

  modport slave (
    input  in_valid, a, b, alu_ctrl, carry_in, out_ready,
    output in_ready, out_valid, result, flags, div_zero
  );

endinterface

// File: rtl/alu_div_iter.sv
// rtl/alu_div_iter.sv - restoring unsigned divider, one quotient bit per cycle over WIDTH cycles
// done_o flags the final iteration; quotient_o then carries the finished quotient for capture.
module alu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // A set remainder MSB means the shifted value exceeds any WIDTH-bit divisor.
  assign trial      = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
  assign fits       = rem_q[WIDTH-1] || (trial >= dvsr_q);
  assign quotient_o = {quot_q[WIDTH-2:0], fits};
  assign done_o     = busy_q && (cnt_q == LAST);
  assign busy_o     = busy_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quot_d = dividend_i;
      dvsr_d = divisor_i;
    end else if (busy_q) begin
      rem_d  = fits ? (trial - dvsr_q) : trial;
      quot_d = quotient_o;
      cnt_d  = cnt_q + CW'(1);
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked execute-stage ALU with NZCV flags, iterative MUL and DIV
// Define ALU_SEQ_FAST_MUL_EN to make MUL a single-cycle operation.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_MUL  = 2'(ST_MUL);
  localparam logic [1:0] S_DIV  = 2'(ST_DIV);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             div_zero_q, div_zero_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
  logic [WIDTH-1:0] mul_mcand_q, mul_mcand_d;
  logic [WIDTH-1:0] mul_mplier_q, mul_mplier_d;
  logic [CW-1:0]    iter_q, iter_d;

  alu_op_e          op;
  logic             in_ready;
  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic             shift_oob;
  logic [WIDTH-1:0] sc_result;
  logic             sc_c;
  logic             sc_v;
  logic [WIDTH-1:0] mul_acc_nx;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;

  function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign op       = alu_op_e'(bus.alu_ctrl);
  assign in_ready = (state_q == S_IDLE) && !div_busy;
  assign accept   = bus.in_valid && in_ready;

  // SUB as a + ~b + 1 so the carry out is the ARM "no borrow" C flag.
  assign add_sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, (op == OP_ADC) && bus.carry_in};
  assign sub_diff  = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  assign shl_ext   = {1'b0, bus.a} << bus.b;
  assign shr_ext   = {bus.a, 1'b0} >> bus.b;
  assign shift_oob = (bus.b >= WIDTH_V);

  always_comb begin
    sc_result = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    case (op)
      OP_PASS: sc_result = bus.a;
      OP_ADD, OP_ADC: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_c      = add_sum[WIDTH];
        sc_v      = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_diff[WIDTH-1:0];
        sc_c      = sub_diff[WIDTH];
        sc_v      = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
`ifdef ALU_SEQ_FAST_MUL_EN
      OP_MUL: sc_result = bus.a * bus.b;
`endif
      OP_SHL: begin
        if (!shift_oob) begin
          sc_result = shl_ext[WIDTH-1:0];
          sc_c      = shl_ext[WIDTH];
        end
      end
      OP_SHR: begin
        if (!shift_oob) begin
          sc_result = shr_ext[WIDTH:1];
          sc_c      = shr_ext[0];
        end
      end
      default: ;
    endcase
  end

  assign mul_acc_nx = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    flags_d      = flags_q;
    div_zero_d   = div_zero_q;
    dz_pend_d    = dz_pend_q;
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    iter_d       = iter_q;
    div_start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_DIV: begin
              state_d   = S_DIV;
              div_start = 1'b1;
              dz_pend_d = (bus.b == '0);
            end
`ifndef ALU_SEQ_FAST_MUL_EN
            OP_MUL: begin
              state_d      = S_MUL;
              mul_acc_d    = '0;
              mul_mcand_d  = bus.a;
              mul_mplier_d = bus.b;
              iter_d       = '0;
            end
`endif
            default: begin
              state_d    = S_DONE;
              result_d   = sc_result;
              flags_d    = nzcv(sc_result, sc_c, sc_v);
              div_zero_d = 1'b0;
            end
          endcase
        end
      end
      S_MUL: begin
        mul_acc_d    = mul_acc_nx;
        mul_mcand_d  = {mul_mcand_q[WIDTH-2:0], 1'b0};
        mul_mplier_d = {1'b0, mul_mplier_q[WIDTH-1:1]};
        iter_d       = iter_q + CW'(1);
        if (iter_q == LAST) begin
          state_d    = S_DONE;
          result_d   = mul_acc_nx;
          flags_d    = nzcv(mul_acc_nx, 1'b0, 1'b0);
          div_zero_d = 1'b0;
        end
      end
      S_DIV: begin
        if (div_done) begin
          state_d    = S_DONE;
          result_d   = div_quot;
          flags_d    = nzcv(div_quot, 1'b0, 1'b0);
          div_zero_d = dz_pend_q;
        end
      end
      default: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      result_q     <= '0;
      flags_q      <= '0;
      div_zero_q   <= 1'b0;
      dz_pend_q    <= 1'b0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      iter_q       <= '0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      div_zero_q   <= div_zero_d;
      dz_pend_q    <= dz_pend_d;
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      iter_q       <= iter_d;
    end
  end

  alu_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start_i   (div_start),
    .dividend_i(bus.a),
    .divisor_i (bus.b),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quot)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=32), honours ALU_SEQ_FAST_MUL_EN
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  alu_seq_if #(.WIDTH(W)) ifc ();

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, output logic [W-1:0] r, output logic [3:0] f,
                                output logic dz, output int lat);
    longint unsigned wa, wb, t;
    longint sa, sb, st;
    logic c, v;
    wa = a; wb = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; dz = 1'b0; lat = 1; r = '0;
    case (op)
      4'd0: r = a;
      4'd1, 4'd7: begin
        t  = wa + wb + ((op == 4'd7 && cin) ? 1 : 0);
        st = sa + sb + ((op == 4'd7 && cin) ? 1 : 0);
        r  = t[W-1:0];
        c  = t[W];
        v  = (st != longint'($signed(r)));
      end
      4'd2: begin
        r  = a - b;
        st = sa - sb;
        c  = (a >= b);
        v  = (st != longint'($signed(r)));
      end
      4'd3: begin
        t   = wa * wb;
        r   = t[W-1:0];
        lat = MUL_LAT;
      end
      4'd4: begin
        r   = (b == 0) ? '1 : a / b;
        dz  = (b == 0);
        lat = W + 1;
      end
      4'd5: if (b < W) begin
        r = a << b;
        if (b != 0) c = a[W - int'(b)];
      end
      4'd6: if (b < W) begin
        r = a >> b;
        if (b != 0) c = a[int'(b) - 1];
      end
      default: r = '0;
    endcase
    f = {r[W-1], (r == 0), c, v};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output logic [W-1:0] r, output logic [3:0] f,
                        output logic dz, output int lat, output int rdy_seen);
    int w;
    w = 0;
    @(negedge clk);
    while (!ifc.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    ifc.in_valid = 1'b1;
    ifc.alu_ctrl = op;
    ifc.a        = a;
    ifc.b        = b;
    ifc.carry_in = cin;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.a        = $urandom;
    ifc.b        = $urandom;
    ifc.alu_ctrl = 4'($urandom);
    ifc.carry_in = 1'($urandom);
    lat = 1;
    rdy_seen = 0;
    while (!ifc.out_valid && lat < 200) begin
      if (ifc.in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    r  = ifc.result;
    f  = ifc.flags;
    dz = ifc.div_zero;
  endtask

  task automatic release_out();
    ifc.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.result !== '0 || ifc.flags !== 4'b0 || ifc.div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b result=%h flags=%b div_zero=%b, required 0/0/0000/0",
               ifc.out_valid, ifc.result, ifc.flags, ifc.div_zero);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", ifc.in_ready);
    end
  endtask

  task automatic test_add_sub();
    logic [W-1:0] r; logic [3:0] f; logic dz; int lat, rs;
    run_op(4'd1, 32'd4, 32'd6, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'd10 || f !== 4'b0000 || lat !== 1) begin
      failures++;
      $display("FAIL add_4_6: result=%h flags=%b lat=%0d, required 0000000a/0000/1", r, f, lat);
    end
    release_out();
    run_op(4'd2, 32'd4, 32'd6, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'hFFFF_FFFE || f !== 4'b1000) begin
      failures++;
      $display("FAIL sub_4_6: result=%h flags=%b, required fffffffe/1000", r, f);
    end
    release_out();
    run_op(4'd2, 32'd6, 32'd6, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'd0 || f !== 4'b0110) begin
      failures++;
      $display("FAIL sub_6_6: result=%h flags=%b, required 00000000/0110", r, f);
    end
    release_out();
  endtask

  task automatic test_mul();
    logic [W-1:0] r; logic [3:0] f; logic dz; int lat, rs;
    run_op(4'd3, 32'd4, 32'd6, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'd24 || lat !== MUL_LAT || rs !== 0) begin
      failures++;
      $display("FAIL mul_4_6: result=%0d lat=%0d ready_cycles=%0d, required 24/%0d/0", r, lat, rs, MUL_LAT);
    end
    release_out();
  endtask

  task automatic test_div();
    logic [W-1:0] r; logic [3:0] f; logic dz; int lat, rs;
    run_op(4'd4, 32'd6, 32'd4, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'd1 || dz !== 1'b0 || lat !== W + 1) begin
      failures++;
      $display("FAIL div_6_4: result=%h div_zero=%b lat=%0d, required 1/0/%0d", r, dz, lat, W + 1);
    end
    release_out();
    run_op(4'd4, 32'd6, 32'd0, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'hFFFF_FFFF || dz !== 1'b1 || f !== 4'b1000 || lat !== W + 1) begin
      failures++;
      $display("FAIL div_by_zero: result=%h div_zero=%b flags=%b lat=%0d, required ffffffff/1/1000/%0d",
               r, dz, f, lat, W + 1);
    end
    release_out();
  endtask

  task automatic test_shift();
    logic [W-1:0] r; logic [3:0] f; logic dz; int lat, rs;
    run_op(4'd5, 32'd4, 32'd2, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'd16 || f !== 4'b0000) begin
      failures++;
      $display("FAIL shl_4_2: result=%h flags=%b, required 00000010/0000", r, f);
    end
    release_out();
    run_op(4'd6, 32'd4, 32'd3, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'd0 || f !== 4'b0110) begin
      failures++;
      $display("FAIL shr_4_3: result=%h flags=%b, required 00000000/0110", r, f);
    end
    release_out();
    run_op(4'd5, 32'd4, 32'd40, 1'b0, r, f, dz, lat, rs);
    checks++;
    if (r !== 32'd0 || f !== 4'b0100) begin
      failures++;
      $display("FAIL shl_b40: result=%h flags=%b, required 00000000/0100", r, f);
    end
    release_out();
  endtask

  task automatic test_hold();
    logic [W-1:0] r, er, a, b; logic [3:0] f, ef; logic dz, edz; int lat, el, rs;
    a = $urandom; b = $urandom;
    model(4'd1, a, b, 1'b0, er, ef, edz, el);
    run_op(4'd1, a, b, 1'b0, r, f, dz, lat, rs);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc.result !== er || ifc.flags !== ef || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: result=%h flags=%b ov=%b ir=%b, required %h/%b/1/0",
                 i, ifc.result, ifc.flags, ifc.out_valid, ifc.in_ready, er, ef);
      end
      @(negedge clk);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; logic [3:0] f; logic dz; int lat, rs;
    run_op(4'd0, 32'h1234_5678, 32'd0, 1'b0, r, f, dz, lat, rs);
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.alu_ctrl  = 4'd1;
    ifc.a         = 32'd1;
    ifc.b         = 32'd2;
    ifc.carry_in  = 1'b0;
    checks++;
    if (ifc.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_release_ready: in_ready=%b required 0", ifc.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    ifc.out_ready = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_bubble: out_valid=%b in_ready=%b required 0/1", ifc.out_valid, ifc.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.result !== 32'd3) begin
      failures++;
      $display("FAIL b2b_second: out_valid=%b result=%h required 1/00000003", ifc.out_valid, ifc.result);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [W-1:0] r, er, a, b; logic [3:0] f, ef, op; logic dz, edz, cin; int lat, el, rs;
    for (int n = 0; n < 60; n++) begin
      op  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom);
      if (op == 4'd5 || op == 4'd6) b = $urandom_range(0, 40);
      if (op == 4'd4) begin
        case ($urandom_range(0, 3))
          0: b = 0;
          1: b = $urandom_range(1, 1000);
          default: ;
        endcase
      end
      model(op, a, b, cin, er, ef, edz, el);
      run_op(op, a, b, cin, r, f, dz, lat, rs);
      checks++;
      if (r !== er || f !== ef || dz !== edz || lat !== el || rs !== 0) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h cin=%b: result=%h flags=%b dz=%b lat=%0d rdy=%0d, required %h/%b/%b/%0d/0",
                 n, op, a, b, cin, r, f, dz, lat, rs, er, ef, edz, el);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_out();
    end
  endtask

  task automatic test_reset_mid_div();
    logic [W-1:0] r; logic [3:0] f; logic dz; int lat, rs, seen;
    run_op(4'd1, 32'd5, 32'd5, 1'b0, r, f, dz, lat, rs);
    release_out();
    ifc.in_valid = 1'b1;
    ifc.alu_ctrl = 4'd4;
    ifc.a        = 32'd100;
    ifc.b        = 32'd7;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.result !== '0 || ifc.flags !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_div: out_valid=%b result=%h flags=%b required 0/0/0000",
               ifc.out_valid, ifc.result, ifc.flags);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_div_ready: in_ready=%b required 1", ifc.in_ready);
    end
    seen = 0;
    repeat (40) begin
      if (ifc.out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_mid_div_abandon: out_valid high %0d cycles, required 0", seen);
    end
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.alu_ctrl  = '0;
    ifc.carry_in  = 1'b0;
    ifc.out_ready = 1'b0;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_shift();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
